// File: rtl/lzd_pkg.sv
// Shared types and elaboration helpers for the iterative leading-zero
// counter / normalizer (lzd_norm_seq) and its chunk LZD (lzd_chunk).
//
// Contents:
//   lzd_state_e     - sequencer states (IDLE, SCAN, DONE)
//   cntw()          - width of a count that must represent 0..width
//   chunk_cfg_ok()  - legality of a WIDTH/CHUNK pairing, checked at elaboration
package lzd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } lzd_state_e;

  // Bits needed to hold a leading-zero count in 0..width inclusive.
  function automatic int cntw(input int width);
    return $clog2(width + 1);
  endfunction

  // The operand must split into whole chunks, and the chunk must be a
  // power of two no smaller than one 2-bit LZD cell.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 2) && ((chunk & (chunk - 1)) == 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/lzd_chunk.sv
// Combinational leading-zero detector for one CHUNK-bit slice.
//
// A log2(CHUNK)-level tree of 2-bit LZD cells. Each node carries (p, v):
// v = some bit below this node is set, p = leading zeros within the node.
// Merging a more-significant node L with a less-significant node R of
// size 2^l gives v = vL | vR and p = vL ? pL : (2^l + pR).
//
// Ports:
//   d     in  CHUNK          slice, d[CHUNK-1] is the most significant bit
//   count out clog2(CHUNK)   leading zeros of d (meaningful when valid=1)
//   valid out 1              d is nonzero
module lzd_chunk #(
  parameter int CHUNK = 8,
  localparam int CL   = $clog2(CHUNK)
) (
  input  logic [CHUNK-1:0] d,
  output logic [CL-1:0]    count,
  output logic             valid
);

  always_comb begin : tree_b
    logic [CL-1:0] p [CHUNK];
    logic          v [CHUNK];
    // Leaves: node 0 is the MSB, so lower node index means more significant.
    for (int i = 0; i < CHUNK; i++) begin
      v[i] = d[CHUNK-1-i];
      p[i] = '0;
    end
    // Merge pairs in place; node i at the next level only overwrites
    // entries that have already been consumed at this level.
    for (int l = 0; l < CL; l++) begin
      for (int i = 0; i < (CHUNK >> (l + 1)); i++) begin
        if (v[2*i]) begin
          p[i] = p[2*i];
        end else begin
          p[i]    = p[2*i+1];
          p[i][l] = 1'b1;
        end
        v[i] = v[2*i] | v[2*i+1];
      end
    end
    count = p[0];
    valid = v[0];
  end

endmodule

// File: rtl/lzd_norm_seq.sv
// Iterative leading-zero counter and left normalizer for the Box-Muller
// log/sqrt argument path. Scans the operand MSB-first, one CHUNK-bit slice
// per cycle, through a single shared lzd_chunk.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and the result stays stable until it is taken with out_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand offered
//   in_ready   out  1      block can accept an operand
//   in_data    in   WIDTH  operand
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes the result
//   out_lzc    out  CNTW   leading-zero count, 0..WIDTH
//   out_norm   out  WIDTH  operand shifted left by out_lzc
//   out_zero   out  1      operand was all zeros
module lzd_norm_seq
  import lzd_pkg::*;
#(
  parameter int  WIDTH = 48,
  parameter int  CHUNK = 8,
  localparam int CNTW  = cntw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  out_lzc,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CL     = $clog2(CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("lzd_norm_seq: WIDTH must be a multiple of CHUNK, CHUNK a power of two >= 2");
  end

  lzd_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_q;
  logic [CNTW-1:0]  cnt_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] top;
  logic [CL-1:0]    z;
  logic             top_nz;

  assign top = op_q[WIDTH-1 -: CHUNK];

  lzd_chunk #(.CHUNK(CHUNK)) u_chunk (
    .d     (top),
    .count (z),
    .valid (top_nz)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Stop on the first nonzero slice, or after the last slice.
        if (top_nz || (idx_q == LAST_IDX)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath. Result registers are written only on the final SCAN cycle,
  // so they hold through DONE and remain readable after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      out_lzc  <= '0;
      out_norm <= '0;
      out_zero <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= in_data;
            cnt_q <= '0;
            idx_q <= '0;
          end
        end
        ST_SCAN: begin
          if (top_nz) begin
            out_lzc  <= cnt_q + CNTW'(z);
            out_norm <= op_q << z;
            out_zero <= 1'b0;
          end else if (idx_q != LAST_IDX) begin
            op_q  <= op_q << CHUNK;
            cnt_q <= cnt_q + CNTW'(CHUNK);
            idx_q <= idx_q + 1'b1;
          end else begin
            out_lzc  <= CNTW'(WIDTH);
            out_norm <= '0;
            out_zero <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzd_norm_seq.sv
module tb_lzd_norm_seq;

  localparam int WIDTH = 48;
  localparam int CNTW  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  out_lzc;
  logic [WIDTH-1:0] out_norm;
  logic             out_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lzd_norm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lzc   (out_lzc),
    .out_norm  (out_norm),
    .out_zero  (out_zero)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand for exactly one edge (caller ensures DUT is in IDLE).
  task automatic drive_accept(input logic [WIDTH-1:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises; -1 if it never does within budget.
  task automatic wait_valid(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (out_valid !== 1'b1) k = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_lzc !== 6'd0) $display("FAIL reset_lzc: got %0d want 0", out_lzc); else pass_cnt++;
    total_cnt++; if (out_norm !== 48'h0) $display("FAIL reset_norm: got %h want 0", out_norm); else pass_cnt++;
    total_cnt++; if (out_zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", out_zero); else pass_cnt++;
  endtask

  // Directed operands: data, expected lzc, norm, zero flag and latency k.
  task automatic test_vectors();
    logic [WIDTH-1:0] vd   [5] = '{48'h800000000000, 48'h00F000000000, 48'h000001234567,
                                   48'h000000000001, 48'h000000000000};
    logic [CNTW-1:0]  vlzc [5] = '{6'd0, 6'd8, 6'd23, 6'd47, 6'd48};
    logic [WIDTH-1:0] vnorm[5] = '{48'h800000000000, 48'hF00000000000, 48'h91A2B3800000,
                                   48'h800000000000, 48'h000000000000};
    logic             vzero[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int               vk   [5] = '{1, 2, 3, 6, 6};
    int k;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      drive_accept(vd[i]);
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL v%0d_busy: in_ready got %b want 0", i, in_ready); else pass_cnt++;
      wait_valid(k);
      total_cnt++; if (k !== vk[i]) $display("FAIL v%0d_latency: got %0d want %0d", i, k, vk[i]); else pass_cnt++;
      total_cnt++; if (out_lzc !== vlzc[i]) $display("FAIL v%0d_lzc: got %0d want %0d", i, out_lzc, vlzc[i]); else pass_cnt++;
      total_cnt++; if (out_norm !== vnorm[i]) $display("FAIL v%0d_norm: got %h want %h", i, out_norm, vnorm[i]); else pass_cnt++;
      total_cnt++; if (out_zero !== vzero[i]) $display("FAIL v%0d_zero: got %b want %b", i, out_zero, vzero[i]); else pass_cnt++;
      tick();  // out_ready=1 completes the handshake
      out_ready = 1'b0;
      total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL v%0d_idle: valid/ready got %b/%b want 0/1", i, out_valid, in_ready); else pass_cnt++;
      total_cnt++; if (out_lzc !== vlzc[i]) $display("FAIL v%0d_lzc_hold: got %0d want %0d", i, out_lzc, vlzc[i]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int k;
    out_ready = 1'b0;
    drive_accept(48'h00F000000000);
    wait_valid(k);
    total_cnt++; if (k !== 2) $display("FAIL bp_latency: got %0d want 2", k); else pass_cnt++;
    in_valid = 1'b1;
    in_data  = 48'h800000000000;
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold_hs c%0d: valid/ready got %b/%b want 1/0", c, out_valid, in_ready); else pass_cnt++;
      total_cnt++; if (out_lzc !== 6'd8 || out_norm !== 48'hF00000000000 || out_zero !== 1'b0)
        $display("FAIL bp_hold_data c%0d: got %0d %h %b want 8 f00000000000 0", c, out_lzc, out_norm, out_zero); else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();  // DONE -> IDLE
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: valid/ready got %b/%b want 0/1", out_valid, in_ready); else pass_cnt++;
    tick();  // pending in_valid accepted here
    in_valid = 1'b0;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_accept: in_ready got %b want 0", in_ready); else pass_cnt++;
    wait_valid(k);
    total_cnt++; if (k !== 1) $display("FAIL bp2_latency: got %0d want 1", k); else pass_cnt++;
    total_cnt++; if (out_lzc !== 6'd0 || out_norm !== 48'h800000000000)
      $display("FAIL bp2_result: got %0d %h want 0 800000000000", out_lzc, out_norm); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    out_ready = 1'b1;
    drive_accept(48'h000000000001);
    repeat (2) tick();  // now in the 3rd SCAN cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_mid_state: ready/valid got %b/%b want 1/0", in_ready, out_valid); else pass_cnt++;
    total_cnt++; if (out_lzc !== 6'd0 || out_norm !== 48'h0 || out_zero !== 1'b0)
      $display("FAIL rst_mid_regs: got %0d %h %b want 0 0 0", out_lzc, out_norm, out_zero); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total_cnt++; if (seen !== 0) $display("FAIL rst_mid_no_result: out_valid seen %0d cycles want 0", seen); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
